// File: rtl/yl3_monitor_if.sv
// Pin and result bundle for the YL-3 display bus monitor.
// master drives the bus pins; slave is the monitor that receives them.
interface yl3_monitor_if;
  logic        sclk;
  logic        sda;
  logic        slatch;
  logic [63:0] seg_raw;
  logic [63:0] chars;
  logic        frame_valid;
  logic        err;

  modport master (
    output sclk, sda, slatch,
    input  seg_raw, chars, frame_valid, err
  );

  modport slave (
    input  sclk, sda, slatch,
    output seg_raw, chars, frame_valid, err
  );
endinterface

// File: rtl/yl3_monitor.sv
// Oversampling receiver for the YL-3 serial 7-segment bus; rebuilds 8-digit frames.
// Define YL3_MON_DECODE_EN to build the ASCII decoder driving bus.chars.
module yl3_monitor #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic          clk,
  input logic          rst,
  yl3_monitor_if.slave bus
);

  typedef enum logic {StShifting, StLatching} phase_e;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_sda_sync, r_slatch_sync;
  logic        r_sclk_dly, r_sda_dly, r_slatch_dly;
  logic        r_sclk_rise, r_slatch_rise;
  logic        w_sclk_rise, w_slatch_rise;

  logic [15:0] r_shreg, w_shreg_nxt;
  logic [4:0]  r_bit_cnt, w_cnt_nxt;
  logic [7:0]  w_sel;
  logic        w_word_ok;

  phase_e      r_phase;
  logic        r_eval_ok;
  logic [7:0]  r_eval_seg, r_eval_sel;
  logic [63:0] r_slots, w_slots_wr;
  logic [7:0]  r_mask, w_mask_wr;
  logic        w_frame;
  logic [63:0] r_seg_raw;
  logic        r_frame_valid, r_err;

  assign w_sclk_rise   = r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_dly;
  assign w_slatch_rise = r_slatch_sync[SYNC_STAGES-1] & ~r_slatch_dly;

  // sda rides one stage behind the sync chain so it lines up with the registered sclk edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_sync   <= '0;
      r_sda_sync    <= '0;
      r_slatch_sync <= '0;
      r_sclk_dly    <= 1'b0;
      r_sda_dly     <= 1'b0;
      r_slatch_dly  <= 1'b0;
      r_sclk_rise   <= 1'b0;
      r_slatch_rise <= 1'b0;
      r_shreg       <= '0;
      r_bit_cnt     <= '0;
    end else begin
      r_sclk_sync   <= {r_sclk_sync[SYNC_STAGES-2:0], bus.sclk};
      r_sda_sync    <= {r_sda_sync[SYNC_STAGES-2:0], bus.sda};
      r_slatch_sync <= {r_slatch_sync[SYNC_STAGES-2:0], bus.slatch};
      r_sclk_dly    <= r_sclk_sync[SYNC_STAGES-1];
      r_sda_dly     <= r_sda_sync[SYNC_STAGES-1];
      r_slatch_dly  <= r_slatch_sync[SYNC_STAGES-1];
      r_sclk_rise   <= w_sclk_rise;
      r_slatch_rise <= w_slatch_rise;
      r_shreg       <= w_shreg_nxt;
      r_bit_cnt     <= r_slatch_rise ? 5'd0 : w_cnt_nxt;
    end
  end

  always_comb begin
    w_shreg_nxt = r_shreg;
    w_cnt_nxt   = r_bit_cnt;
    if (r_sclk_rise) begin
      w_shreg_nxt = {r_shreg[14:0], r_sda_dly};
      if (r_bit_cnt != 5'd31) w_cnt_nxt = r_bit_cnt + 5'd1;
    end
  end

  // Latch check sees the post-shift word, so a coincident 16th sclk edge is counted.
  assign w_sel     = w_shreg_nxt[7:0];
  assign w_word_ok = (w_cnt_nxt == 5'd16) && (w_sel != 8'd0) &&
                     ((w_sel & (w_sel - 8'd1)) == 8'd0);

  // Select bit i addresses digit 7-i, which sits at byte i of the packed slot buffer.
  always_comb begin
    w_slots_wr = r_slots;
    w_mask_wr  = r_mask;
    for (int i = 0; i < 8; i++) begin
      if (r_eval_sel[i]) begin
        w_slots_wr[8*i +: 8] = r_eval_seg;
        w_mask_wr[i]         = 1'b1;
      end
    end
  end

  assign w_frame = (r_phase == StLatching) && r_eval_ok && (w_mask_wr == 8'hFF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase       <= StShifting;
      r_eval_ok     <= 1'b0;
      r_eval_seg    <= '0;
      r_eval_sel    <= '0;
      r_slots       <= '1;
      r_mask        <= '0;
      r_seg_raw     <= '1;
      r_frame_valid <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_frame_valid <= 1'b0;
      unique case (r_phase)
        StShifting: begin
          if (r_slatch_rise) begin
            r_phase    <= StLatching;
            r_eval_ok  <= w_word_ok;
            r_eval_seg <= w_shreg_nxt[15:8];
            r_eval_sel <= w_sel;
          end
        end
        StLatching: begin
          r_phase <= StShifting;
          if (r_eval_ok) begin
            r_slots <= w_slots_wr;
            if (w_frame) begin
              r_mask        <= '0;
              r_seg_raw     <= w_slots_wr;
              r_frame_valid <= 1'b1;
            end else begin
              r_mask <= w_mask_wr;
            end
          end else begin
            r_err <= 1'b1;
          end
        end
        default: r_phase <= StShifting;
      endcase
    end
  end

  assign bus.seg_raw     = r_seg_raw;
  assign bus.frame_valid = r_frame_valid;
  assign bus.err         = r_err;

`ifdef YL3_MON_DECODE_EN
  logic [63:0] r_chars, w_chars_nxt;

  // Argument is the raw active-low a..g field; dp never affects the character.
  function automatic logic [7:0] f_decode(input logic [6:0] seg_n);
    logic [6:0] p;
    p = ~seg_n;
    case (p)
      7'h3F:   f_decode = "0";
      7'h06:   f_decode = "1";
      7'h5B:   f_decode = "2";
      7'h4F:   f_decode = "3";
      7'h66:   f_decode = "4";
      7'h6D:   f_decode = "5";
      7'h7D:   f_decode = "6";
      7'h07:   f_decode = "7";
      7'h7F:   f_decode = "8";
      7'h6F:   f_decode = "9";
      7'h77:   f_decode = "A";
      7'h39:   f_decode = "C";
      7'h79:   f_decode = "E";
      7'h71:   f_decode = "F";
      7'h76:   f_decode = "H";
      7'h38:   f_decode = "L";
      7'h73:   f_decode = "P";
      7'h3E:   f_decode = "U";
      7'h40:   f_decode = "-";
      7'h00:   f_decode = " ";
      default: f_decode = "?";
    endcase
  endfunction

  always_comb begin
    w_chars_nxt = '0;
    for (int i = 0; i < 8; i++) begin
      w_chars_nxt[8*i +: 8] = f_decode(w_slots_wr[8*i +: 7]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chars <= 64'h2020_2020_2020_2020;
    end else if (w_frame) begin
      r_chars <= w_chars_nxt;
    end
  end

  assign bus.chars = r_chars;
`else
  assign bus.chars = 64'h2020_2020_2020_2020;
`endif

endmodule

// File: tb/tb_yl3_monitor.sv
// Self-checking bench for yl3_monitor: drives the YL-3 pins and compares against a
// digit-array model of the display frame.
module tb_yl3_monitor;
  localparam int SYNC = 2;
  localparam int LAT  = SYNC + 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  yl3_monitor_if bus ();

  yl3_monitor #(.SYNC_STAGES(SYNC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: digit-indexed slots, digit 0 leftmost.
  logic [7:0]  m_slot [8];
  logic [7:0]  m_mask;
  logic        m_err;
  logic [63:0] m_seg_raw;
  logic [63:0] m_chars;

  typedef struct {
    logic [7:0] seg;
    logic [7:0] sel;
    int         nbits;
  } word_t;

  function automatic logic [7:0] exp_char(input logic [7:0] seg);
`ifdef YL3_MON_DECODE_EN
    logic [6:0] p;
    p = ~seg[6:0];
    case (p)
      7'h3F: return "0";
      7'h06: return "1";
      7'h5B: return "2";
      7'h4F: return "3";
      7'h66: return "4";
      7'h6D: return "5";
      7'h7D: return "6";
      7'h07: return "7";
      7'h7F: return "8";
      7'h6F: return "9";
      7'h77: return "A";
      7'h39: return "C";
      7'h79: return "E";
      7'h71: return "F";
      7'h76: return "H";
      7'h38: return "L";
      7'h73: return "P";
      7'h3E: return "U";
      7'h40: return "-";
      7'h00: return " ";
      default: return "?";
    endcase
`else
    return 8'h20;
`endif
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 8; d++) m_slot[d] = 8'hFF;
    m_mask    = '0;
    m_err     = 1'b0;
    m_seg_raw = '1;
    m_chars   = 64'h2020_2020_2020_2020;
  endtask

  task automatic model_word(input logic [7:0] seg, input logic [7:0] sel, input int nbits,
                            output bit frame);
    int ones;
    int dig;
    frame = 1'b0;
    ones  = 0;
    dig   = 0;
    for (int i = 0; i < 8; i++) begin
      if (sel[7-i]) begin
        ones++;
        dig = i;
      end
    end
    if (nbits == 16 && ones == 1) begin
      m_slot[dig] = seg;
      m_mask[dig] = 1'b1;
      if (m_mask == 8'hFF) begin
        frame  = 1'b1;
        m_mask = '0;
        for (int d = 0; d < 8; d++) begin
          m_seg_raw[63-8*d -: 8] = m_slot[d];
          m_chars[63-8*d -: 8]   = exp_char(m_slot[d]);
        end
      end
    end else begin
      m_err = 1'b1;
    end
  endtask

  task automatic do_reset();
    bus.sclk   = 1'b0;
    bus.sda    = 1'b0;
    bus.slatch = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
  endtask

  // Shifts the first nbits of {seg, sel} MSB first, latches, and watches frame_valid.
  // pulse_at counts posedges from the first one that samples slatch high (that edge is 0).
  task automatic send_word(input logic [7:0] seg, input logic [7:0] sel, input int nbits,
                           input bit simul, output int pulses, output int pulse_at);
    logic [15:0] w;
    w        = {seg, sel};
    pulses   = 0;
    pulse_at = -1;
    for (int i = 0; i < nbits; i++) begin
      bus.sda = w[15-i];
      repeat (4) @(negedge clk);
      bus.sclk = 1'b1;
      if (simul && i == nbits - 1) begin
        bus.slatch = 1'b1;
      end else begin
        repeat (4) @(negedge clk);
        bus.sclk = 1'b0;
      end
    end
    if (!bus.slatch) begin
      repeat (4) @(negedge clk);
      bus.slatch = 1'b1;
    end
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      if (bus.frame_valid === 1'b1) begin
        if (pulse_at < 0) pulse_at = k;
        pulses++;
      end
    end
    bus.slatch = 1'b0;
    bus.sclk   = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_full_frame();
    logic [7:0] segs [8];
    int pulses, at, last_at;
    bit f;
    segs = '{8'hFF, 8'hFF, 8'hFF, 8'h89, 8'h86, 8'hC7, 8'hC7, 8'hC0};
    last_at = -1;
    do_reset();
    for (int d = 0; d < 8; d++) begin
      send_word(segs[d], 8'h80 >> d, 16, 1'b0, pulses, at);
      model_word(segs[d], 8'h80 >> d, 16, f);
      n_checks++;
      if (pulses != (f ? 1 : 0)) begin
        n_fail++;
        $display("FAIL full_frame pulses d%0d: got %0d want %0d", d, pulses, f ? 1 : 0);
      end
      if (f) last_at = at;
    end
    n_checks++;
    if (last_at != LAT) begin
      n_fail++;
      $display("FAIL full_frame latency: got %0d want %0d", last_at, LAT);
    end
    n_checks++;
    if (bus.seg_raw[39:32] !== 8'h89) begin
      n_fail++;
      $display("FAIL full_frame digit3: got %h want 89", bus.seg_raw[39:32]);
    end
    n_checks++;
    if (bus.seg_raw !== m_seg_raw) begin
      n_fail++;
      $display("FAIL full_frame seg_raw: got %h want %h", bus.seg_raw, m_seg_raw);
    end
    n_checks++;
    if (bus.chars !== m_chars) begin
      n_fail++;
      $display("FAIL full_frame chars: got %h want %h", bus.chars, m_chars);
    end
`ifdef YL3_MON_DECODE_EN
    n_checks++;
    if (bus.chars !== "   HELL0") begin
      n_fail++;
      $display("FAIL full_frame text: got \"%s\" want \"   HELL0\"", bus.chars);
    end
`endif
    n_checks++;
    if (bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL full_frame err: got %b want 0", bus.err);
    end
  endtask

  task automatic test_short_word();
    int pulses, at;
    bit f;
    do_reset();
    // A wrongly accepted 15-bit word would land in digit 7 and finish the frame early.
    send_word(8'hC0, 8'h02, 15, 1'b0, pulses, at);
    model_word(8'hC0, 8'h02, 15, f);
    n_checks++;
    if (bus.err !== 1'b1 || pulses != 0) begin
      n_fail++;
      $display("FAIL short_word err/pulses: got %b/%0d want 1/0", bus.err, pulses);
    end
    for (int d = 0; d < 8; d++) begin
      send_word(8'hF9 ^ 8'(d), 8'h80 >> d, 16, 1'b0, pulses, at);
      model_word(8'hF9 ^ 8'(d), 8'h80 >> d, 16, f);
      n_checks++;
      if (pulses != (f ? 1 : 0)) begin
        n_fail++;
        $display("FAIL short_word pulses d%0d: got %0d want %0d", d, pulses, f ? 1 : 0);
      end
    end
    n_checks++;
    if (bus.err !== m_err) begin
      n_fail++;
      $display("FAIL short_word sticky err: got %b want %b", bus.err, m_err);
    end
    n_checks++;
    if (bus.seg_raw !== m_seg_raw) begin
      n_fail++;
      $display("FAIL short_word seg_raw: got %h want %h", bus.seg_raw, m_seg_raw);
    end
  endtask

  task automatic test_reset();
    int pulses, at;
    bit f;
    // Leave 9 bits in the shift register, then reset asynchronously between edges.
    for (int i = 0; i < 9; i++) begin
      bus.sda = i[0];
      repeat (4) @(negedge clk);
      bus.sclk = 1'b1;
      repeat (4) @(negedge clk);
      bus.sclk = 1'b0;
    end
    repeat (4) @(negedge clk);
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if (bus.seg_raw !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      n_fail++;
      $display("FAIL reset seg_raw: got %h want ffffffffffffffff", bus.seg_raw);
    end
    n_checks++;
    if (bus.chars !== 64'h2020_2020_2020_2020) begin
      n_fail++;
      $display("FAIL reset chars: got %h want 2020202020202020", bus.chars);
    end
    n_checks++;
    if (bus.frame_valid !== 1'b0 || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset fv/err: got %b/%b want 0/0", bus.frame_valid, bus.err);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    send_word(8'h92, 8'h01, 16, 1'b0, pulses, at);
    model_word(8'h92, 8'h01, 16, f);
    n_checks++;
    if (bus.err !== m_err || pulses != 0) begin
      n_fail++;
      $display("FAIL reset next word err/pulses: got %b/%0d want %b/0", bus.err, pulses, m_err);
    end
  endtask

  task automatic test_bad_select();
    int order [8];
    int pulses, at;
    bit f;
    order = '{0, 1, 2, 5, 6, 7, 3, 4};
    do_reset();
    send_word(8'h92, 8'h18, 16, 1'b0, pulses, at);
    model_word(8'h92, 8'h18, 16, f);
    n_checks++;
    if (bus.err !== 1'b1 || pulses != 0) begin
      n_fail++;
      $display("FAIL bad_select err/pulses: got %b/%0d want 1/0", bus.err, pulses);
    end
    // Digits 3 and 4 come last: a mask polluted by the bad select would fire early.
    for (int j = 0; j < 8; j++) begin
      send_word(8'hB0 | 8'(j), 8'h80 >> order[j], 16, 1'b0, pulses, at);
      model_word(8'hB0 | 8'(j), 8'h80 >> order[j], 16, f);
      n_checks++;
      if (pulses != (f ? 1 : 0)) begin
        n_fail++;
        $display("FAIL bad_select pulses d%0d: got %0d want %0d", order[j], pulses, f ? 1 : 0);
      end
    end
    n_checks++;
    if (bus.seg_raw !== m_seg_raw || bus.err !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_select seg_raw/err: got %h/%b want %h/1", bus.seg_raw, bus.err,
               m_seg_raw);
    end
  endtask

  task automatic test_simultaneous();
    int pulses, at;
    bit f;
    do_reset();
    for (int d = 0; d < 7; d++) begin
      send_word(8'hF9, 8'h80 >> d, 16, 1'b0, pulses, at);
      model_word(8'hF9, 8'h80 >> d, 16, f);
    end
    send_word(8'hA4, 8'h01, 16, 1'b1, pulses, at);
    model_word(8'hA4, 8'h01, 16, f);
    n_checks++;
    if (pulses != 1 || at != LAT) begin
      n_fail++;
      $display("FAIL simultaneous pulse: got %0d@%0d want 1@%0d", pulses, at, LAT);
    end
    n_checks++;
    if (bus.err !== 1'b0 || bus.seg_raw[7:0] !== 8'hA4) begin
      n_fail++;
      $display("FAIL simultaneous err/digit7: got %b/%h want 0/a4", bus.err, bus.seg_raw[7:0]);
    end
    n_checks++;
    if (bus.chars !== m_chars) begin
      n_fail++;
      $display("FAIL simultaneous chars: got %h want %h", bus.chars, m_chars);
    end
  endtask

  task automatic test_overwrite();
    int order [8];
    logic [7:0] segv [8];
    int pulses, at;
    bit f;
    order = '{2, 0, 1, 2, 3, 4, 5, 6};
    segv  = '{8'hC0, 8'h7F, 8'h7F, 8'hF9, 8'h7F, 8'h7F, 8'h7F, 8'h7F};
    do_reset();
    for (int j = 0; j < 8; j++) begin
      send_word(segv[j], 8'h80 >> order[j], 16, 1'b0, pulses, at);
      model_word(segv[j], 8'h80 >> order[j], 16, f);
      n_checks++;
      if (pulses != 0) begin
        n_fail++;
        $display("FAIL overwrite early pulse j%0d: got %0d want 0", j, pulses);
      end
    end
    send_word(8'h7F, 8'h01, 16, 1'b0, pulses, at);
    model_word(8'h7F, 8'h01, 16, f);
    n_checks++;
    if (pulses != 1 || bus.err !== 1'b0) begin
      n_fail++;
      $display("FAIL overwrite frame: got %0d/%b want 1/0", pulses, bus.err);
    end
    n_checks++;
    if (bus.seg_raw !== 64'h7F7F_F97F_7F7F_7F7F) begin
      n_fail++;
      $display("FAIL overwrite seg_raw: got %h want 7f7ff97f7f7f7f7f", bus.seg_raw);
    end
    n_checks++;
    if (bus.chars !== m_chars) begin
      n_fail++;
      $display("FAIL overwrite chars: got %h want %h", bus.chars, m_chars);
    end
`ifdef YL3_MON_DECODE_EN
    n_checks++;
    if (bus.chars !== 64'h2020_3120_2020_2020) begin
      n_fail++;
      $display("FAIL overwrite text: got %h want 2020312020202020", bus.chars);
    end
`else
    n_checks++;
    if (bus.chars !== 64'h2020_2020_2020_2020) begin
      n_fail++;
      $display("FAIL overwrite blank chars: got %h want 2020202020202020", bus.chars);
    end
`endif
  endtask

  task automatic test_random();
    logic [6:0] pats [20];
    word_t q[$];
    word_t w;
    int perm [8];
    int tmp, j, a, b, pulses, at;
    bit f;
    pats = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F,
             7'h77, 7'h39, 7'h79, 7'h71, 7'h76, 7'h38, 7'h73, 7'h3E, 7'h40, 7'h00};
    do_reset();
    for (int fr = 0; fr < 3; fr++) begin
      for (int i = 0; i < 8; i++) perm[i] = i;
      for (int i = 7; i > 0; i--) begin
        j = int'($urandom_range(0, i));
        tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
      end
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          a = int'($urandom_range(0, 7));
          b = (a + 1 + int'($urandom_range(0, 6))) % 8;
          w.seg   = 8'($urandom);
          w.sel   = 8'(1 << a) | 8'(1 << b);
          w.nbits = 16;
          q.push_back(w);
        end
        if ($urandom_range(0, 3) == 0) w.seg = 8'($urandom);
        else w.seg = {($urandom_range(0, 1) == 1), ~pats[$urandom_range(0, 19)]};
        w.sel   = 8'h80 >> perm[i];
        w.nbits = ($urandom_range(0, 15) == 0) ? 14 : 16;
        q.push_back(w);
      end
    end
    foreach (q[i]) begin
      send_word(q[i].seg, q[i].sel, q[i].nbits, 1'b0, pulses, at);
      model_word(q[i].seg, q[i].sel, q[i].nbits, f);
      n_checks++;
      if (pulses != (f ? 1 : 0) || (f && at != LAT)) begin
        n_fail++;
        $display("FAIL random pulse w%0d: got %0d@%0d want %0d@%0d", i, pulses, at, f ? 1 : 0,
                 LAT);
      end
      n_checks++;
      if (bus.err !== m_err) begin
        n_fail++;
        $display("FAIL random err w%0d: got %b want %b", i, bus.err, m_err);
      end
      n_checks++;
      if (bus.seg_raw !== m_seg_raw || bus.chars !== m_chars) begin
        n_fail++;
        $display("FAIL random frame w%0d: got %h/%h want %h/%h", i, bus.seg_raw, bus.chars,
                 m_seg_raw, m_chars);
      end
    end
  endtask

  initial begin
    do_reset();
    test_full_frame();
    test_short_word();
    test_reset();
    test_bad_select();
    test_simultaneous();
    test_overwrite();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/yl3_monitor.md
# yl3_monitor

Serial-side receiver for the YL-3 8-digit 7-segment display bus. It samples the SCK/DIO/RCK lines that the display driver produces, reassembles each 16-bit shift-register word, and rebuilds the 8-digit frame as raw segment bytes and decoded ASCII. It is a loopback/monitor block: the top level wires it to the same pins the display driver drives, so the bench or on-board logic can check what was actually shown.

## Interface
- `SYNC_STAGES`, default 2: flip-flop depth of the input synchronizer on `sclk`, `sda` and `slatch`; legal range 2–4.
- `clk` in 1: system clock, 50 MHz.
- `rst` in 1: asynchronous, active-high reset.
- `sclk` in 1: YL-3 shift clock, asynchronous to `clk`.
- `sda` in 1: YL-3 serial data, asynchronous to `clk`.
- `slatch` in 1: YL-3 latch (RCK), asynchronous to `clk`.
- `seg_raw` out 64: captured segment bytes, active-low. Digit 0 (leftmost) is in [63:56]; digit 7 is in [7:0].
- `chars` out 64: ASCII decode of the last complete frame. Same digit order as `seg_raw`.
- `frame_valid` out 1: one-cycle pulse when a complete frame has been captured.
- `err` out 1: sticky protocol-error flag, cleared only by `rst`.

## Operation
- **Synchronizer:** each pin passes through `SYNC_STAGES` flip-flops, then one delay register for edge detection. Rising edges are detected on `sclk` and `slatch` only.
- **Shift:** on a `sclk` rising edge, `shreg[15:0] <= {shreg[14:0], sda_sync}`. The 5-bit `bit_cnt` increments and saturates at 31.
- **Word format:** the first 8 bits shifted are the segment byte, active-low, MSB first (bit7 = dp, bit6..0 = g..a). The next 8 bits are the digit select, one-hot active-high, where bit7 selects digit 0.
- **Latch:** on a `slatch` rising edge the word is accepted only if `bit_cnt == 16` and the select byte is exactly one-hot.
  - **Accepted:** the segment byte is written to digit slot `d` and `mask[d]` is set.
  - **Rejected:** `err <= 1` and nothing is written.
  - In both cases `bit_cnt` returns to 0.
- **Frame:** when an accepted write makes `mask == 8'hFF`:
  - `seg_raw` and `chars` update together from the slot buffer, including the word just latched;
  - `frame_valid` pulses;
  - `mask` clears.
  - Writes to an already-set slot overwrite it with no error. `seg_raw` changes only at frame completion.
- **Decode:** uses pattern `p = ~seg[6:0]`, ignoring dp.

| p | char |
|---|------|
| 3F | '0' |
| 06 | '1' |
| 5B | '2' |
| 4F | '3' |
| 66 | '4' |
| 6D | '5' |
| 7D | '6' |
| 07 | '7' |
| 7F | '8' |
| 6F | '9' |
| 77 | 'A' |
| 39 | 'C' |
| 79 | 'E' |
| 71 | 'F' |
| 76 | 'H' |
| 38 | 'L' |
| 73 | 'P' |
| 3E | 'U' |
| 40 | '-' |
| 00 | ' ' |
| any other | '?' |

  'O' and '0' share a pattern and both decode to '0'.
- **Simultaneous edges:** if `sclk` and `slatch` edges are detected in the same cycle, the shift is applied first. The latch check then uses the post-shift `shreg` and `bit_cnt`.
- **State:** the block has two implicit phases.
  - `SHIFTING`: `bit_cnt` is counting.
  - `LATCHING`: a single-cycle evaluation on the latch edge, which always returns to `SHIFTING` with `bit_cnt = 0`.
- **Reset:** asynchronous assertion clears everything immediately. A partial word or partial frame in progress is discarded.

## Timing
- **Reset values:**
  - `seg_raw = 64'hFFFF_FFFF_FFFF_FFFF` (blank);
  - `chars = 64'h2020_2020_2020_2020`;
  - `frame_valid = 0`, `err = 0`;
  - internally, `mask = 0`, `bit_cnt = 0`, `shreg = 0`, and every slot is `8'hFF`.
- **Latency:** `frame_valid`, `seg_raw`, `chars` and `err` update on the clk edge `SYNC_STAGES + 2` cycles after the first clk edge that samples `slatch` high. With the default, that is 4 cycles.
- **Minimum pin timing:** `sclk` and `slatch` high and low widths must each be at least `SYNC_STAGES + 1` clk periods. `sda` must be stable for at least `SYNC_STAGES + 1` clk periods before the `sclk` rise. Edges violating this may be missed; that is not flagged.
- `frame_valid` is exactly one cycle wide. Back-to-back frames produce distinct pulses.

## Configuration
- **`YL3_MON_DECODE_EN` defined:**
  - the ASCII decode table is compiled in;
  - `chars` behaves as described above.
- **`YL3_MON_DECODE_EN` not defined:**
  - no decode logic is built;
  - `chars` is tied to the constant `64'h2020_2020_2020_2020`;
  - all other behaviour is unchanged.

## Test plan
- **Reset:** assert `rst` mid-word after 9 `sclk` edges, then release.
  - Required: outputs hold their reset values.
  - Required: the next valid 16-bit word is accepted with no `err`.
- **Full frame:** send 8 words spelling "HELLO" right-aligned, digits 0–7 in order.
  - Digit 3 carries segment byte `8'h89` and select `8'h10`.
  - Required: exactly one `frame_valid` pulse, 4 clks after the last latch.
  - Required: `chars = "   HELL0"`; `seg_raw[39:32] = 8'h89`.
- **Short word:** send 15 bits, then latch.
  - Required: `err` rises and no slot is written.
  - Required: after a following full frame, `frame_valid` still pulses and `err` stays 1.
- **Bad select:** send a 16-bit word with select `8'h18` (two bits set).
  - Required: `err = 1` and `mask` is unchanged.
  - Required: a frame completes only after all 8 slots are validly written.
- **Simultaneous edges:** drive the 16th `sclk` rise and the `slatch` rise on the same clk edge.
  - Required: the word is accepted with the 16th bit included.
- **Overwrite and decode:** write digit 2 twice, first `8'hC0` then `8'hF9`, then complete the frame with `8'h7F` (pattern `0x00`) elsewhere.
  - Required: `chars[47:40] = "1"`; every other slot is `" "`.
  - Required without `YL3_MON_DECODE_EN`: `chars` is all `8'h20` and `seg_raw` is identical to the decode build.
